// File: rtl/ppu_pkg.sv
// Shared PPU definitions: ALU op codes, RV32I opcodes, operand-select encodings
// and the decoded control bundle carried from decode to execute.
package ppu_pkg;

  localparam logic [3:0] ALU_PASS_B   = 4'd0;
  localparam logic [3:0] ALU_PASS_B4  = 4'd1;
  localparam logic [3:0] ALU_ADD      = 4'd2;
  localparam logic [3:0] ALU_SUB      = 4'd3;
  localparam logic [3:0] ALU_ADD_CLR0 = 4'd4;
  localparam logic [3:0] ALU_SLL      = 4'd5;
  localparam logic [3:0] ALU_SRL      = 4'd6;
  localparam logic [3:0] ALU_SRA      = 4'd7;
  localparam logic [3:0] ALU_SLT      = 4'd8;
  localparam logic [3:0] ALU_SLTU     = 4'd9;
  localparam logic [3:0] ALU_AND      = 4'd10;
  localparam logic [3:0] ALU_OR       = 4'd11;
  localparam logic [3:0] ALU_XOR      = 4'd12;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic       SRC_A_RS1 = 1'b0;
  localparam logic       SRC_A_PC  = 1'b1;
  localparam logic [1:0] SRC_B_RS2 = 2'd0;
  localparam logic [1:0] SRC_B_IMM = 2'd1;
  localparam logic [1:0] SRC_B_PC  = 2'd2;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       src_a_sel;
    logic [1:0] src_b_sel;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [2:0] branch_cond;
    logic       jump;
    logic       illegal;
  } decoded_t;

  // Shared funct3 map of OP and OP-IMM; alt selects sub/sra where they exist.
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3, input logic alt);
    logic [3:0] op;
    op = ALU_ADD;
    case (funct3)
      3'b000: op = alt ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_op_decoder_if.sv
// ALU Op interface: decoded control bundle with valid/ready handshake.
// The decoder drives it through master; the execute stage consumes it through slave.
interface alu_op_decoder_if;
  import ppu_pkg::*;

  logic       out_valid;
  logic       out_ready;
  logic [3:0] alu_op;
  logic       src_a_sel;
  logic [1:0] src_b_sel;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       branch;
  logic [2:0] branch_cond;
  logic       jump;
  logic       illegal;

  modport master (
    output out_valid, alu_op, src_a_sel, src_b_sel, reg_write, mem_read,
           mem_write, branch, branch_cond, jump, illegal,
    input  out_ready
  );

  modport slave (
    input  out_valid, alu_op, src_a_sel, src_b_sel, reg_write, mem_read,
           mem_write, branch, branch_cond, jump, illegal,
    output out_ready
  );

endinterface

// File: rtl/ppu_skid_buffer.sv
// Valid/ready pipeline register with one skid entry: full throughput, registered
// in_ready, strict ordering, and a flush that kills both held entries.
module ppu_skid_buffer
  import ppu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             accept;
  logic             out_free;

  assign accept   = in_valid & in_ready_q;
  assign out_free = ~out_valid_q | out_ready;

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_data_d   = out_data_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      // in_ready is low whenever the skid holds data, so no accept competes here
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) out_data_d = in_data;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every flop samples pre-edge values regardless of order.
    if (reset) begin
      // NOTE: data registers are reset as well because outputs must read zero in reset.
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      out_data_q   <= '0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      out_data_q   <= out_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/alu_op_decoder.sv
// RV32I instruction to ALU control decoder: combinational decode feeding a
// skid-buffered output stage that drives the ALU Op interface.
module alu_op_decoder
  import ppu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        instr,
  alu_op_decoder_if.master   op
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       bad;
  logic       unused_operand_bits;
  decoded_t   dec;
  decoded_t   bundle;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign unused_operand_bits = ^{instr[24:15], instr[11:7]};

  always_comb begin
    dec = '0;
    bad = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec.alu_op = ALU_PASS_B; dec.src_b_sel = SRC_B_IMM; dec.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        dec.alu_op = ALU_ADD; dec.src_a_sel = SRC_A_PC; dec.src_b_sel = SRC_B_IMM;
        dec.reg_write = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        dec.alu_op = ALU_PASS_B4; dec.src_b_sel = SRC_B_PC;
        dec.reg_write = 1'b1; dec.jump = 1'b1;
        bad = (opcode == OPC_JALR) && (funct3 != 3'b000);
      end
      OPC_LOAD: begin
        dec.alu_op = ALU_ADD; dec.src_b_sel = SRC_B_IMM;
        dec.mem_read = 1'b1; dec.reg_write = 1'b1;
      end
      OPC_STORE: begin
        dec.alu_op = ALU_ADD; dec.src_b_sel = SRC_B_IMM; dec.mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        dec.alu_op = ALU_SUB; dec.src_b_sel = SRC_B_RS2;
        dec.branch = 1'b1; dec.branch_cond = funct3;
        bad = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_OP_IMM: begin
        // funct7 is immediate data except for the shift encodings
        dec.alu_op = alu_from_funct3(funct3, (funct3 == 3'b101) && (funct7 == F7_ALT));
        dec.src_b_sel = SRC_B_IMM; dec.reg_write = 1'b1;
        bad = ((funct3 == 3'b001) && (funct7 != F7_BASE)) ||
              ((funct3 == 3'b101) && (funct7 != F7_BASE) && (funct7 != F7_ALT));
      end
      OPC_OP: begin
        dec.alu_op = alu_from_funct3(funct3, funct7 == F7_ALT);
        dec.src_b_sel = SRC_B_RS2; dec.reg_write = 1'b1;
        bad = (funct7 == F7_ALT) ? !((funct3 == 3'b000) || (funct3 == 3'b101))
                                 : (funct7 != F7_BASE);
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  ppu_skid_buffer #(.WIDTH($bits(decoded_t))) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (dec),
    .out_valid (op.out_valid),
    .out_ready (op.out_ready),
    .out_data  (bundle)
  );

  assign op.alu_op      = bundle.alu_op;
  assign op.src_a_sel   = bundle.src_a_sel;
  assign op.src_b_sel   = bundle.src_b_sel;
  assign op.reg_write   = bundle.reg_write;
  assign op.mem_read    = bundle.mem_read;
  assign op.mem_write   = bundle.mem_write;
  assign op.branch      = bundle.branch;
  assign op.branch_cond = bundle.branch_cond;
  assign op.jump        = bundle.jump;
  assign op.illegal     = bundle.illegal;

endmodule
